dcacheline_wb_adapter: RTL and testbench
========================================

// Module: dcacheline_wb_adapter
// PURPOSE
// - Write-direction counterpart of the I-cache line fill path.
// - Takes one full cache line from the D-cache writeback port.
// - Transmits the line to BRAM as a DATA_W-wide burst of BEATS beats on the bmem write channel.
// - Sits between the D-cache dfp port and the memory arbiter; one burst in flight at a time.
// PARAMETERS
// - DATA_W  64  bmem beat width in bits
// - BEATS   4   beats per line; LINE_W = DATA_W*BEATS (256); OFF_W = $clog2(LINE_W/8) (5)
// PORTS
// - clk          input   1       single clock; all logic on posedge
// - rst          input   1       asynchronous, active-low reset (asserted when 0)
// - dfp_addr     input   32      line address of dirty line; low OFF_W bits ignored
// - dfp_write    input   1       writeback request; held high until dfp_resp
// - dfp_wdata    input   LINE_W  full line; beat k = dfp_wdata[k*DATA_W +: DATA_W]
// - dfp_resp     output  1       one-cycle pulse: line accepted/written
// - bmem_ready   input   1       memory accepts the current beat this cycle
// - bmem_addr    output  32      burst base address {dfp_addr[31:OFF_W], OFF_W'b0}
// - bmem_write   output  1       write beat valid
// - bmem_wdata   output  DATA_W  current beat data
// BEHAVIOUR
// - Reset (async, rst==0): state=IDLE, beat=0, line/addr regs=0.
//   All outputs 0 immediately, without waiting for clk.
//   Reset mid-burst abandons the burst; no dfp_resp is issued for it.
// - FSM IDLE -> SEND -> RESP -> IDLE.
// - IDLE: outputs 0. On dfp_write=1: capture dfp_wdata, aligned dfp_addr; beat<=0; go to SEND.
// - SEND: bmem_write=1, bmem_addr=captured base, bmem_wdata=line[beat].
//   - Beat transfers in a cycle with bmem_write && bmem_ready: beat<=beat+1.
//   - bmem_ready=0: beat, addr and data held stable (no bubbles inserted, no beat dropped).
//   - Transfer of beat BEATS-1: go to RESP. beat counter is $clog2(BEATS) bits, wraps to 0.
// - RESP: dfp_resp=1 for exactly one cycle, then IDLE.
// - Latency with bmem_ready tied high: request seen at cycle 0, beats in cycles 1..4, dfp_resp at cycle 5.
//   Each stall cycle adds one.
// - Requests accepted only in IDLE. dfp_write high during RESP is not double-counted.
//   The next line is captured in the IDLE cycle after RESP, so back-to-back writebacks have one idle cycle.
// - dfp_addr/dfp_wdata/dfp_write changes after capture have no effect on the burst in flight.
// - bmem_addr constant across all beats of a burst. Beat order is strictly 0..BEATS-1.
// CONFIGURATION
// - Macro DCACHE_WB_POSTED_EN.
// - Undefined (default): behaviour above; dfp_resp only after the last beat is accepted.
// - Defined: posted writeback.
//   - dfp_resp pulses in the cycle after capture, i.e. the first SEND cycle.
//   - The burst then completes from the internal copy; RESP state is skipped (SEND -> IDLE after the last beat).
//   - A dfp_write arriving while SEND is active is not acknowledged.
//   - That request is captured in the first IDLE cycle after the burst ends.
//   - Its dfp_resp follows one cycle later.
// - Data on bmem is identical in both builds.
// TESTING
// - Single line, ready=1, addr=0x0000_1234, wdata beats {D0..D3}:
//   - bmem_addr=0x0000_1220 on 4 consecutive cycles, wdata D0,D1,D2,D3.
//   - dfp_resp pulse 1 cycle after D3.
// - Stalls: bmem_ready low 3 cycles before beat1 and 1 cycle before beat3:
//   - Beat values held during stalls.
//   - Exactly 4 transfers; dfp_resp at cycle 9.
// - Back-to-back: dfp_write held high with new addr 0x40 / data E0..E3 right after first dfp_resp:
//   - Second burst starts 2 cycles after first resp.
//   - Addr 0x40; no duplicate resp.
// - Async reset: drive rst=0 mid-cycle during beat 2:
//   - bmem_write and dfp_resp 0 before the next clk edge.
//   - After release, with no dfp_write, outputs stay 0.
// - Input change after capture: flip dfp_wdata and dfp_addr in cycle 1:
//   - Burst still emits the originally captured addr/data.
// - DCACHE_WB_POSTED_EN defined, ready=1:
//   - dfp_resp at cycle 1.
//   - A second request at cycle 2 gets dfp_resp only at cycle 6.
//   - Its beats follow immediately after the first burst.

Source files
------------

// File: rtl/dcacheline_wb_adapter.sv
// dcacheline_wb_adapter
//   Write-direction cache line adapter. It accepts one dirty line from the
//   D-cache writeback port and replays it to memory as a burst of BEATS beats.
//   Each beat is DATA_W bits wide. Only one burst is in flight at a time.
//
// Ports
//   clk         single clock; all state changes on its rising edge
//   rst         asynchronous reset, active low
//   dfp_addr    line address; the low OFF_W bits are ignored
//   dfp_write   writeback request, held high until dfp_resp
//   dfp_wdata   full line; beat k is dfp_wdata[k*DATA_W +: DATA_W]
//   dfp_resp    one-cycle pulse: the line has been accepted
//   bmem_ready  memory accepts the current beat this cycle
//   bmem_addr   aligned burst base address, constant over the burst
//   bmem_write  beat valid
//   bmem_wdata  current beat data
//
// Build option
//   DCACHE_WB_POSTED_EN  When defined, dfp_resp pulses in the first SEND
//                        cycle. The burst then drains from the internal copy
//                        and the RESP state is skipped. When undefined,
//                        dfp_resp follows the last accepted beat.
//                        The data sent on bmem is the same in both builds.
module dcacheline_wb_adapter #(
  parameter int DATA_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               dfp_addr,
  input  logic                      dfp_write,
  input  logic [DATA_W*BEATS-1:0]   dfp_wdata,
  output logic                      dfp_resp,
  input  logic                      bmem_ready,
  output logic [31:0]               bmem_addr,
  output logic                      bmem_write,
  output logic [DATA_W-1:0]         bmem_wdata
);

  localparam int LINE_W = DATA_W * BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [BEAT_W-1:0]   beat_reg,  beat_next;
  logic [LINE_W-1:0]   line_reg,  line_next;
  logic [31:0]         addr_reg,  addr_next;
  logic [31:0]         aligned_addr;
  logic [DATA_W-1:0]   beat_data [BEATS];
  logic                addr_offset_unused;

`ifdef DCACHE_WB_POSTED_EN
  // This flag is high only in the first SEND cycle after a capture.
  // The early acknowledge is raised in that cycle.
  logic                first_reg, first_next;
`endif

  // The byte offset within the line is dropped on purpose.
  // The burst always starts at the line base.
  assign aligned_addr       = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign addr_offset_unused = ^dfp_addr[OFF_W-1:0];

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign beat_data[gi] = line_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      line_reg  <= '0;
      addr_reg  <= '0;
`ifdef DCACHE_WB_POSTED_EN
      first_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      line_reg  <= line_next;
      addr_reg  <= addr_next;
`ifdef DCACHE_WB_POSTED_EN
      first_reg <= first_next;
`endif
    end
  end

  // The outputs depend only on the registers.
  // An asynchronous reset therefore clears them at once, without a clock edge.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    line_next  = line_reg;
    addr_next  = addr_reg;
`ifdef DCACHE_WB_POSTED_EN
    first_next = 1'b0;
`endif
    dfp_resp   = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;

    case (state_reg)
      IDLE: begin
        if (dfp_write) begin
          line_next  = dfp_wdata;
          addr_next  = aligned_addr;
          beat_next  = '0;
          state_next = SEND;
`ifdef DCACHE_WB_POSTED_EN
          first_next = 1'b1;
`endif
        end
      end

      SEND: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_reg;
        bmem_wdata = beat_data[beat_reg];
`ifdef DCACHE_WB_POSTED_EN
        dfp_resp   = first_reg;
`endif
        // Without ready everything holds, so the same beat is presented again.
        if (bmem_ready) begin
          beat_next = beat_reg + BEAT_W'(1);
          if (beat_reg == LAST_BEAT) begin
`ifdef DCACHE_WB_POSTED_EN
            state_next = IDLE;
`else
            state_next = RESP;
`endif
          end
        end
      end

      RESP: begin
        // A dfp_write that is still high here belongs to the line just finished.
        // It is ignored.
        dfp_resp   = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcacheline_wb_adapter.sv
module tb_dcacheline_wb_adapter;

  localparam int DATA_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = DATA_W * BEATS;

`ifdef DCACHE_WB_POSTED_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       dfp_addr = '0;
  logic              dfp_write = 1'b0;
  logic [LINE_W-1:0] dfp_wdata = '0;
  logic              dfp_resp;
  logic              bmem_ready = 1'b1;
  logic [31:0]       bmem_addr;
  logic              bmem_write;
  logic [DATA_W-1:0] bmem_wdata;

  dcacheline_wb_adapter #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk        (clk),
    .rst        (rst),
    .dfp_addr   (dfp_addr),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_resp   (dfp_resp),
    .bmem_ready (bmem_ready),
    .bmem_addr  (bmem_addr),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       addr;
    logic [DATA_W-1:0] data;
  } beat_t;

  typedef struct {
    logic [31:0]       addr;
    logic [LINE_W-1:0] data;
    logic [31:0]       exp_addr;
    logic [31:0]       rdy;       // bit k = bmem_ready in cycle k after the request
    int                exp_resp;  // dfp_resp cycle in the non-posted build
    bit                scramble;  // change addr/data in cycle 1
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[5];
  int    vec_cnt    = 0;
  int    err_cnt    = 0;
  int    resp_total = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base, input logic [LINE_W-1:0] data);
    beat_t e;
    for (int b = 0; b < BEATS; b++) begin
      e.addr = base;
      e.data = data[b*DATA_W +: DATA_W];
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard. Every presented beat must match the head of the queue.
  // The head is popped only when the beat is accepted.
  // Stalled beats are therefore compared against the same entry again.
  always @(negedge clk) begin
    if (rst && dfp_resp) resp_total++;
    if (rst && bmem_write) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        err_cnt++;
        $display("FAIL unexpected_beat: got addr %08h data %016h, expected no beat", bmem_addr, bmem_wdata);
      end else begin
        if (bmem_addr !== exp_q[0].addr || bmem_wdata !== exp_q[0].data) begin
          err_cnt++;
          $display("FAIL beat: got addr %08h data %016h, expected addr %08h data %016h",
                   bmem_addr, bmem_wdata, exp_q[0].addr, exp_q[0].data);
        end
        if (bmem_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_line(input int id, input vec_t v);
    int  k;
    int  resp_cyc;
    int  r0;
    bit  done;
    int  exp_resp;
    exp_resp = POSTED ? 1 : v.exp_resp;
    resp_cyc = -1;
    done     = 1'b0;
    k        = 0;
    tick();
    r0 = resp_total;
    push_line(v.exp_addr, v.data);
    dfp_addr   = v.addr;
    dfp_wdata  = v.data;
    dfp_write  = 1'b1;
    bmem_ready = v.rdy[0];
    while (!done && k < 40) begin
      tick();
      k++;
      if (resp_cyc >= 0) dfp_write = 1'b0;
      bmem_ready = (k < 32) ? v.rdy[k] : 1'b1;
      if (v.scramble && k == 1) begin
        dfp_addr  = ~v.addr;
        dfp_wdata = ~v.data;
      end
      if (resp_cyc >= 0 && exp_q.size() == 0 && !bmem_write) done = 1'b1;
      @(negedge clk);
      if (dfp_resp && resp_cyc < 0) resp_cyc = k;
    end
    dfp_write  = 1'b0;
    bmem_ready = 1'b1;
    tick();
    tick();
    check($sformatf("vec%0d_resp_cycle", id), 64'(resp_cyc), 64'(exp_resp));
    check($sformatf("vec%0d_beats_left", id), 64'(exp_q.size()), 64'd0);
    check($sformatf("vec%0d_resp_count", id), 64'(resp_total - r0), 64'd1);
    $display("vec %0d: addr=%08h base=%08h resp_cycle=%0d", id, v.addr, v.exp_addr, resp_cyc);
    exp_q.delete();
  endtask

  initial begin
    int k, nresp, r1, r2, b2, r0;
    bit sw, drop;
    logic [LINE_W-1:0] line_e;

    vecs[0] = '{32'h0000_1234,
                {64'hD3D3_0000_0000_00D3, 64'hD2D2_0000_0000_00D2,
                 64'hD1D1_0000_0000_00D1, 64'hD0D0_0000_0000_00D0},
                32'h0000_1220, 32'hFFFF_FFFF, 5, 1'b0};
    vecs[1] = '{32'h8000_003F,
                256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_A5A5_5A5A_0F0F_F0F0_1122_3344_5566_7788,
                32'h8000_0020, 32'hFFFF_FFFF, 5, 1'b1};
    vecs[2] = '{32'h0000_1000,
                {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                 64'h1111_1111_1111_1111, 64'h0000_0000_0000_0001},
                32'h0000_1000, ~32'h0000_009C, 9, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF,
                {64'hCAFE_0003_0000_0003, 64'hCAFE_0002_0000_0002,
                 64'hCAFE_0001_0000_0001, 64'hCAFE_0000_0000_0000},
                32'hFFFF_FFE0, ~32'h0000_0002, 6, 1'b0};
    vecs[4] = '{32'h0000_0000, {LINE_W{1'b1}},
                32'h0000_0000, ~32'h0000_0014, 7, 1'b0};

    // Reset is applied before any clock edge; the outputs must clear immediately.
    #1 rst = 1'b0;
    #1;
    check("rst_bmem_write", 64'(bmem_write), 64'd0);
    check("rst_dfp_resp",   64'(dfp_resp),   64'd0);
    check("rst_bmem_addr",  64'(bmem_addr),  64'd0);
    check("rst_bmem_wdata", 64'(bmem_wdata), 64'd0);
    tick();
    tick();
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_line(i, vecs[i]);

    // Back-to-back: dfp_write stays high and switches to the next line after the first resp.
    line_e = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
              64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
    tick();
    push_line(32'h0000_1220, vecs[0].data);
    push_line(32'h0000_0040, line_e);
    dfp_addr  = 32'h0000_1234;
    dfp_wdata = vecs[0].data;
    dfp_write = 1'b1;
    nresp = 0; r1 = -1; r2 = -1; b2 = -1; sw = 1'b0; drop = 1'b0;
    for (k = 1; k <= 16; k++) begin
      tick();
      if (sw) begin
        dfp_addr  = 32'h0000_0040;
        dfp_wdata = line_e;
        sw = 1'b0;
      end
      if (drop) dfp_write = 1'b0;
      @(negedge clk);
      if (dfp_resp) begin
        nresp++;
        if (nresp == 1) begin r1 = k; sw = 1'b1; end
        else if (nresp == 2) begin r2 = k; drop = 1'b1; end
      end
      if (bmem_write && bmem_addr == 32'h0000_0040 && b2 < 0) b2 = k;
    end
    dfp_write = 1'b0;
    check("b2b_resp1_cycle",  64'(r1), POSTED ? 64'd1 : 64'd5);
    check("b2b_burst2_start", 64'(b2), POSTED ? 64'd6 : 64'd7);
    check("b2b_resp2_cycle",  64'(r2), POSTED ? 64'd6 : 64'd11);
    check("b2b_resp_count",   64'(nresp), 64'd2);
    check("b2b_beats_left",   64'(exp_q.size()), 64'd0);
    $display("b2b: resp1=%0d burst2=%0d resp2=%0d", r1, b2, r2);
    exp_q.delete();

    // Async reset in the middle of beat 2; the burst is abandoned.
    tick();
    push_line(32'h0000_0300, vecs[2].data);
    dfp_addr   = 32'h0000_0300;
    dfp_wdata  = vecs[2].data;
    dfp_write  = 1'b1;
    bmem_ready = 1'b1;
    for (k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
    end
    check("arst_pre_write", 64'(bmem_write), 64'd1);
    #1;
    rst       = 1'b0;
    dfp_write = 1'b0;
    #1;
    check("arst_bmem_write", 64'(bmem_write), 64'd0);
    check("arst_dfp_resp",   64'(dfp_resp),   64'd0);
    check("arst_bmem_addr",  64'(bmem_addr),  64'd0);
    check("arst_bmem_wdata", 64'(bmem_wdata), 64'd0);
    exp_q.delete();
    r0 = resp_total;
    tick();
    tick();
    rst = 1'b1;
    for (k = 0; k < 8; k++) begin
      tick();
      @(negedge clk);
      check("post_rst_idle", {62'd0, bmem_write, dfp_resp}, 64'd0);
    end
    check("post_rst_resp_count", 64'(resp_total - r0), 64'd0);
    $display("async reset: burst abandoned, outputs idle");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
